hwpe_stream_burst_arbiter: RTL and testbench



---
 rtl/hwpe_stream_burst_arbiter_pkg.sv | 29 ++
 rtl/hwpe_stream_intf_stream.sv | 15 +
 rtl/hwpe_stream_rr_pick.sv | 36 +++
 rtl/hwpe_stream_burst_arbiter.sv | 136 +++++++++++++
 tb/tb_hwpe_stream_burst_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_burst_arbiter_pkg.sv
// Shared types and helpers for the HWPE-Stream burst arbiter.
// The controller and the bench can use the ctrl/flags structs when they bundle arbiter signals.
package hwpe_stream_burst_arbiter_pkg;

  localparam int unsigned ArbMaxNbIn   = 16;
  localparam int unsigned ArbMaxBurstW = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  typedef struct packed {
    logic                    enable;
    logic [ArbMaxBurstW-1:0] burst_len;
  } arb_ctrl_t;

  typedef struct packed {
    logic                  busy;
    logic [ArbMaxNbIn-1:0] grant;
    logic                  timeout;
  } arb_flags_t;

  // Next round-robin slot after idx, wrapping at n.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream valid/ready interface carrying data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping at NB_IN.
module hwpe_stream_rr_pick #(
  parameter int unsigned NB_IN = 4,
  localparam int unsigned IdxW = (NB_IN > 1) ? $clog2(NB_IN) : 1
) (
  input  logic [NB_IN-1:0] i_req,
  input  logic [IdxW-1:0]  i_ptr,
  output logic [NB_IN-1:0] o_gnt,
  output logic [IdxW-1:0]  o_idx,
  output logic             o_any
);

  int unsigned       w_pos;
  logic [IdxW-1:0]   w_sel;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 32'd0;
    w_sel = '0;
    for (int unsigned off = 0; off < NB_IN; off++) begin
      w_pos = 32'(i_ptr) + off;
      if (w_pos >= NB_IN) begin
        w_pos = w_pos - NB_IN;
      end
      w_sel = IdxW'(w_pos);
      if (!o_any && i_req[w_sel]) begin
        o_any        = 1'b1;
        o_idx        = w_sel;
        o_gnt[w_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_burst_arbiter.sv
// Round-robin arbiter sharing one HWPE-Stream sink between NB_IN producers.
// A grant is held for burst_len_i beats (0 = until idle timeout), with one bubble between bursts.
module hwpe_stream_burst_arbiter
  import hwpe_stream_burst_arbiter_pkg::*;
#(
  parameter int unsigned NB_IN        = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BURST_W      = 8,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [BURST_W-1:0]     burst_len_i,
  hwpe_stream_intf_stream.sink   push_i [NB_IN-1:0],
  hwpe_stream_intf_stream.source pop_o,
  output logic [NB_IN-1:0]       grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned IdxW     = (NB_IN > 1) ? $clog2(NB_IN) : 1;
  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned IdleW    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IdleW-1:0]   IdleLast = IdleW'(IDLE_TIMEOUT - 1);
  localparam logic [BURST_W-1:0] BeatMax  = '1;

  arb_state_e         r_state;
  logic [NB_IN-1:0]   r_grant;
  logic [IdxW-1:0]    r_idx;
  logic [IdxW-1:0]    r_ptr;
  logic [BURST_W-1:0] r_len;
  logic [BURST_W-1:0] r_beat;
  logic [IdleW-1:0]   r_idle;
  logic               r_timeout;

  logic [NB_IN-1:0]      w_valid;
  logic [NB_IN-1:0]      w_ready;
  logic [DATA_WIDTH-1:0] w_data [NB_IN];
  logic [StrbW-1:0]      w_strb [NB_IN];
  logic [NB_IN-1:0]      w_gnt;
  logic [IdxW-1:0]       w_pick_idx;
  logic                  w_any;
  logic                  w_live;
  logic                  w_sel_valid;
  logic                  w_pop_valid;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_tmo;

  for (genvar k = 0; k < NB_IN; k++) begin : g_unpack
    assign w_valid[k]     = push_i[k].valid;
    assign w_data[k]      = push_i[k].data;
    assign w_strb[k]      = push_i[k].strb;
    assign push_i[k].ready = w_ready[k];
  end

  hwpe_stream_rr_pick #(
    .NB_IN (NB_IN)
  ) i_rr_pick (
    .i_req (w_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  // Forwarding is cut in a reset/clear cycle so a beat presented there is never transferred.
  assign w_live      = rst_ni & ~clear_i & (r_state == ARB_GRANT);
  assign w_sel_valid = w_valid[r_idx];
  assign w_pop_valid = w_live & w_sel_valid;
  assign w_ready     = r_grant & {NB_IN{w_live & pop_o.ready}};
  assign w_hs        = w_pop_valid & pop_o.ready;
  assign w_last      = w_hs & (r_len != '0) & (r_beat == r_len - 1'b1);
  assign w_tmo       = w_live & ~w_sel_valid & (r_idle == IdleLast);

  assign pop_o.valid = w_pop_valid;
  assign pop_o.data  = w_data[r_idx];
  assign pop_o.strb  = w_strb[r_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (enable_i && w_any) begin
            r_state <= ARB_GRANT;
            r_grant <= w_gnt;
            r_idx   <= w_pick_idx;
            r_len   <= burst_len_i;
            r_beat  <= '0;
            r_idle  <= '0;
          end
        end
        ARB_GRANT: begin
          if (w_hs) begin
            r_idle <= '0;
            if (r_beat != BeatMax) begin
              r_beat <= r_beat + 1'b1;
            end
          end else if (w_sel_valid) begin
            // Sink stall: producer is still valid, so it is not idle.
            r_idle <= '0;
          end else if (!w_tmo) begin
            r_idle <= r_idle + 1'b1;
          end
          if (w_last || w_tmo) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_ptr     <= IdxW'(rr_wrap_inc(32'(r_idx), NB_IN));
            r_timeout <= w_tmo;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign grant_o   = r_grant;
  assign busy_o    = (r_state == ARB_GRANT);
  assign timeout_o = r_timeout;

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_grant));
  a_valid_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) w_pop_valid |-> busy_o);

endmodule

// File: tb/tb_hwpe_stream_burst_arbiter.sv
// Directed bench for hwpe_stream_burst_arbiter: round-robin order, burst length, timeout,
// enable gating, reset/clear mid-burst, with a scoreboard of accepted beats.
module tb_hwpe_stream_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       enable;
  logic [7:0] len;
  logic [3:0] p_valid;
  logic [3:0] p_ready;
  logic       pop_ready;
  logic [3:0] grant;
  logic       busy;
  logic       tmo;

  int unsigned p_seq [4] = '{default: 0};
  logic [35:0] rx [$];
  logic [35:0] exq [$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        m_gnt;
  logic        m_rdy;

  logic [3:0] sched_rr [24] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                                4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0,
                                4'h1, 4'h1, 4'h1, 4'h1};
  logic [3:0] sched_len [9] = '{4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h0};
  bit         pat [12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0};

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push [3:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop ();

  for (genvar k = 0; k < 4; k++) begin : g_prod
    assign push[k].valid = p_valid[k];
    assign push[k].data  = {8'(k), p_seq[k][23:0]};
    assign push[k].strb  = 4'(p_seq[k] + k);
    assign p_ready[k]    = push[k].ready;
  end
  assign pop.ready = pop_ready;

  hwpe_stream_burst_arbiter #(
    .NB_IN        (4),
    .DATA_WIDTH   (32),
    .BURST_W      (8),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .enable_i    (enable),
    .burst_len_i (len),
    .push_i      (push),
    .pop_o       (pop),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (p_valid[k] && p_ready[k]) p_seq[k] <= p_seq[k] + 1;
    end
    if (pop.valid && pop.ready) rx.push_back({pop.strb, pop.data});
  end

  function automatic logic [35:0] mk(input int unsigned k, input int unsigned s);
    logic [31:0] d;
    logic [3:0]  st;
    d  = {8'(k), 24'(s)};
    st = 4'(s + k);
    return {st, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input logic [3:0] g, input logic v, input logic t, input string tag);
    #1;
    chk({tag, "_grant"}, 64'(grant), 64'(g));
    chk({tag, "_busy"}, 64'(busy), 64'(|g));
    chk({tag, "_valid"}, 64'(pop.valid), 64'(v));
    chk({tag, "_ready"}, 64'(p_ready), 64'(g & {4{pop_ready}}));
    chk({tag, "_tmo"}, 64'(tmo), 64'(t));
  endtask

  task automatic add_exp(input int unsigned k, input int unsigned s0, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exq.push_back(mk(k, s0 + i));
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_count"}, 64'(rx.size()), 64'(exq.size()));
    for (int i = 0; i < exq.size(); i++) begin
      if (i < rx.size()) chk($sformatf("%s_beat%0d", tag, i), 64'(rx[i]), 64'(exq[i]));
    end
    rx.delete();
    exq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    enable    = 1'b1;
    len       = 8'd4;
    p_valid   = 4'b1111;
    pop_ready = 1'b1;
    next();
    next();
    obs(4'h0, 1'b0, 1'b0, "reset");

    // Round robin, all inputs valid, bursts of 4; reset lands on beat 3 of the 2nd grant to 0.
    rst_n = 1'b1;
    for (int c = 0; c < 23; c++) begin
      next();
      obs(sched_rr[c], sched_rr[c] != 4'h0, 1'b0, $sformatf("rr%0d", c));
    end
    next();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_grant_before", 64'(grant), 64'(4'h1));
    chk("rst_mid_valid", 64'(pop.valid), 64'(1'b0));
    chk("rst_mid_ready", 64'(p_ready), 64'(4'h0));
    next();
    rst_n   = 1'b1;
    len     = 8'd1;
    p_valid = 4'b0100;
    obs(4'h0, 1'b0, 1'b0, "rst_mid_after");
    add_exp(0, 0, 4);
    add_exp(1, 0, 4);
    add_exp(2, 0, 4);
    add_exp(3, 0, 4);
    add_exp(0, 4, 3);
    chk_rx("rr_rx");

    // Single producer, len 1, sink stalling: re-grant after every beat.
    m_gnt = 1'b0;
    m_rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next();
      if (!m_gnt) m_gnt = 1'b1;
      else if (m_rdy) m_gnt = 1'b0;
      m_rdy     = pat[i];
      pop_ready = m_rdy;
      obs(m_gnt ? 4'h4 : 4'h0, m_gnt, 1'b0, $sformatf("single%0d", i));
    end
    next();
    clear     = 1'b1;
    pop_ready = 1'b1;
    #1;
    chk("clear_grant_before", 64'(grant), 64'(4'h4));
    chk("clear_valid", 64'(pop.valid), 64'(1'b0));
    chk("clear_ready", 64'(p_ready), 64'(4'h0));
    next();
    clear   = 1'b0;
    len     = 8'd0;
    p_valid = 4'b0010;
    obs(4'h0, 1'b0, 1'b0, "clear_after");
    add_exp(2, 4, 4);
    chk_rx("single_rx");

    // Unlimited burst on input 1, then 16 idle cycles force a release to input 2.
    for (int i = 0; i < 3; i++) begin
      next();
      obs(4'h2, 1'b1, 1'b0, $sformatf("unl%0d", i));
    end
    next();
    p_valid = 4'b0100;
    obs(4'h2, 1'b0, 1'b0, "idle1");
    for (int j = 2; j <= 16; j++) begin
      next();
      obs(4'h2, 1'b0, 1'b0, $sformatf("idle%0d", j));
    end
    next();
    obs(4'h0, 1'b0, 1'b1, "tmo_pulse");
    next();
    clear = 1'b1;
    #1;
    chk("tmo_next_grant", 64'(grant), 64'(4'h4));
    chk("tmo_pulse_once", 64'(tmo), 64'(1'b0));
    chk("tmo_clear_valid", 64'(pop.valid), 64'(1'b0));
    next();
    clear   = 1'b0;
    len     = 8'd5;
    p_valid = 4'b0001;
    obs(4'h0, 1'b0, 1'b0, "tmo_clear_after");
    add_exp(1, 4, 3);
    chk_rx("tmo_rx");

    // enable_i drops during a burst of 5: burst completes, then no new grant.
    next();
    enable  = 1'b0;
    p_valid = 4'b1001;
    obs(4'h1, 1'b1, 1'b0, "en_b0");
    for (int i = 1; i < 5; i++) begin
      next();
      obs(4'h1, 1'b1, 1'b0, $sformatf("en_b%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      next();
      obs(4'h0, 1'b0, 1'b0, $sformatf("en_off%0d", i));
    end
    enable = 1'b1;
    len    = 8'd4;

    // burst_len_i changes mid-burst only affect the following grant.
    next();
    obs(4'h8, 1'b1, 1'b0, "len_b0");
    next();
    len = 8'd2;
    obs(4'h8, 1'b1, 1'b0, "len_b1");
    for (int c = 0; c < 9; c++) begin
      next();
      obs(sched_len[c], sched_len[c] != 4'h0, 1'b0, $sformatf("len%0d", c));
    end
    p_valid = 4'b0000;
    add_exp(0, 7, 5);
    add_exp(3, 4, 4);
    add_exp(0, 12, 2);
    add_exp(3, 8, 2);
    chk_rx("en_len_rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
